// File: rtl/des_pkg.sv
// Shared DES tables, FSM state type and block/subkey typedefs for the round engine.
// Table entries use DES bit numbering (1 = MSB); the helpers map them onto vector indices.
package des_pkg;

  typedef logic [47:0] subkey_t;
  typedef logic [63:0] block_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [6:0] IP_TBL [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam logic [6:0] FP_TBL [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25
  };

  localparam logic [5:0] E_TBL [48] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1
  };

  localparam logic [5:0] P_TBL [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25
  };

  // Each S-box row-major: entry index = row*16 + column.
  localparam logic [3:0] SBOX [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
       0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
      15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
       3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
      13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
       1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
      13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
       3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
      14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
      11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
      10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
       4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
      13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
       6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
       1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
       2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}
  };

  function automatic block_t ip_perm(input block_t d);
    block_t o;
    o = '0;
    for (int i = 0; i < 64; i++) o[6'(63 - i)] = d[6'(7'd64 - IP_TBL[6'(i)])];
    return o;
  endfunction

  function automatic block_t fp_perm(input block_t d);
    block_t o;
    o = '0;
    for (int i = 0; i < 64; i++) o[6'(63 - i)] = d[6'(7'd64 - FP_TBL[6'(i)])];
    return o;
  endfunction

  function automatic logic [47:0] e_expand(input logic [31:0] r);
    logic [47:0] o;
    o = '0;
    for (int i = 0; i < 48; i++) o[6'(47 - i)] = r[5'(6'd32 - E_TBL[6'(i)])];
    return o;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] s);
    logic [31:0] o;
    o = '0;
    for (int i = 0; i < 32; i++) o[5'(31 - i)] = s[5'(6'd32 - P_TBL[5'(i)])];
    return o;
  endfunction

endpackage

// File: rtl/des_feistel_f.sv
// DES round function f(R, K): E-expansion, key mix, S1..S8 substitution, P permutation.
// Purely combinational so several instances can be chained within one clock.
module des_feistel_f
  import des_pkg::*;
(
  input  logic [31:0] r_i,
  input  logic [47:0] k_i,
  output logic [31:0] f_o
);

  logic [47:0] x;
  logic [31:0] s;

  assign x = e_expand(r_i) ^ k_i;

  for (genvar g = 0; g < 8; g++) begin : g_sbox
    logic [5:0] b;
    assign b = x[47 - 6*g -: 6];
    // Outer bits pick the row, inner four pick the column.
    assign s[31 - 4*g -: 4] = SBOX[g][{b[5], b[0], b[4:1]}];
  end

  assign f_o = p_perm(s);

endmodule

// File: rtl/des_round_engine.sv
// Iterative DES datapath: UNROLL Feistel rounds per clock, valid/ready on both sides.
// Define DES_DECRYPT_EN to add the mode input and reverse key order for decryption.
//
// state   | meaning
// IDLE    | in_ready high, waiting for a block
// RUN     | applying UNROLL rounds per cycle
// DONE    | out_valid high, holding block_out until out_ready
module des_round_engine
  import des_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] block_in,
  input  logic [47:0] subkey1,
  input  logic [47:0] subkey2,
  input  logic [47:0] subkey3,
  input  logic [47:0] subkey4,
  input  logic [47:0] subkey5,
  input  logic [47:0] subkey6,
  input  logic [47:0] subkey7,
  input  logic [47:0] subkey8,
  input  logic [47:0] subkey9,
  input  logic [47:0] subkey10,
  input  logic [47:0] subkey11,
  input  logic [47:0] subkey12,
  input  logic [47:0] subkey13,
  input  logic [47:0] subkey14,
  input  logic [47:0] subkey15,
  input  logic [47:0] subkey16,
`ifdef DES_DECRYPT_EN
  input  logic        mode,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] block_out
);

  localparam logic [4:0] STEP = 5'(UNROLL);
  localparam logic [4:0] LAST = 5'd16 - STEP;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] l_q, l_d;
  logic [31:0] r_q, r_d;
  block_t      out_q, out_d;
  block_t      ip_blk;
  subkey_t     sk [16];
  logic [31:0] l_chain [UNROLL+1];
  logic [31:0] r_chain [UNROLL+1];

`ifdef DES_DECRYPT_EN
  logic mode_q, mode_d;
`endif

  assign sk[0]  = subkey1;   assign sk[1]  = subkey2;   assign sk[2]  = subkey3;
  assign sk[3]  = subkey4;   assign sk[4]  = subkey5;   assign sk[5]  = subkey6;
  assign sk[6]  = subkey7;   assign sk[7]  = subkey8;   assign sk[8]  = subkey9;
  assign sk[9]  = subkey10;  assign sk[10] = subkey11;  assign sk[11] = subkey12;
  assign sk[12] = subkey13;  assign sk[13] = subkey14;  assign sk[14] = subkey15;
  assign sk[15] = subkey16;

  assign ip_blk     = ip_perm(block_in);
  assign l_chain[0] = l_q;
  assign r_chain[0] = r_q;

  // Subkeys are read live each RUN cycle; upstream keeps them stable for the whole block.
  for (genvar g = 0; g < UNROLL; g++) begin : g_round
    logic [3:0]  rnd;
    logic [3:0]  kidx;
    logic [31:0] f_out;

    assign rnd = cnt_q[3:0] + 4'(g);
`ifdef DES_DECRYPT_EN
    assign kidx = mode_q ? (4'd15 - rnd) : rnd;
`else
    assign kidx = rnd;
`endif

    des_feistel_f u_feistel (
      .r_i (r_chain[g]),
      .k_i (sk[kidx]),
      .f_o (f_out)
    );

    assign l_chain[g+1] = r_chain[g];
    assign r_chain[g+1] = l_chain[g] ^ f_out;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    l_d     = l_q;
    r_d     = r_q;
    out_d   = out_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          l_d     = ip_blk[63:32];
          r_d     = ip_blk[31:0];
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        l_d   = l_chain[UNROLL];
        r_d   = r_chain[UNROLL];
        cnt_d = cnt_q + STEP;
        if (cnt_q == LAST) begin
          // Final swap folded in: output is FP(R16 || L16).
          out_d   = fp_perm({r_chain[UNROLL], l_chain[UNROLL]});
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      l_q     <= '0;
      r_q     <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      l_q     <= l_d;
      r_q     <= r_d;
      out_q   <= out_d;
    end
  end

`ifdef DES_DECRYPT_EN
  always_comb begin
    mode_d = mode_q;
    if (state_q == ST_IDLE && in_valid) mode_d = mode;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mode_q <= 1'b0;
    else     mode_q <= mode_d;
  end
`endif

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign block_out = out_q;

endmodule

// File: tb/tb_des_round_engine.sv
// Self-checking bench for des_round_engine: known-answer vectors, random blocks against a
// whole-block DES reference model, backpressure, reset, UNROLL=2 and back-to-back traffic.
module tb_des_round_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv1, ir1, ov1, ordy1;
  logic        iv2, ir2, ov2, ordy2;
  logic [63:0] bo1, bo2;
  logic [63:0] block_in;
  logic [47:0] sk [1:16];
`ifdef DES_DECRYPT_EN
  logic        mode;
`endif
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  des_round_engine #(.UNROLL(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .block_in(block_in),
    .subkey1(sk[1]), .subkey2(sk[2]), .subkey3(sk[3]), .subkey4(sk[4]),
    .subkey5(sk[5]), .subkey6(sk[6]), .subkey7(sk[7]), .subkey8(sk[8]),
    .subkey9(sk[9]), .subkey10(sk[10]), .subkey11(sk[11]), .subkey12(sk[12]),
    .subkey13(sk[13]), .subkey14(sk[14]), .subkey15(sk[15]), .subkey16(sk[16]),
`ifdef DES_DECRYPT_EN
    .mode(mode),
`endif
    .out_valid(ov1), .out_ready(ordy1), .block_out(bo1)
  );

  des_round_engine #(.UNROLL(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .block_in(block_in),
    .subkey1(sk[1]), .subkey2(sk[2]), .subkey3(sk[3]), .subkey4(sk[4]),
    .subkey5(sk[5]), .subkey6(sk[6]), .subkey7(sk[7]), .subkey8(sk[8]),
    .subkey9(sk[9]), .subkey10(sk[10]), .subkey11(sk[11]), .subkey12(sk[12]),
    .subkey13(sk[13]), .subkey14(sk[14]), .subkey15(sk[15]), .subkey16(sk[16]),
`ifdef DES_DECRYPT_EN
    .mode(mode),
`endif
    .out_valid(ov2), .out_ready(ordy2), .block_out(bo2)
  );

  // ---------------- reference model (standard DES, own tables) ----------------
  localparam int T_IP [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
    62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8, 57,49,41,33,25,17,9,1,
    59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int T_E [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
    16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int T_P [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
    2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  localparam int T_PC1 [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
    10,2,59,51,43,35,27, 19,11,3,60,52,44,36, 63,55,47,39,31,23,15,
    7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int T_PC2 [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
    16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int T_SH [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int T_S [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  // Bit n (1 = MSB) of a w-bit value held right-aligned in d.
  function automatic logic getb(input logic [63:0] d, input int w, input int n);
    logic [63:0] t;
    t = d >> (w - n);
    return t[0];
  endfunction

  function automatic logic [63:0] m_ip(input logic [63:0] d);
    logic [63:0] o = '0;
    for (int i = 0; i < 64; i++) o = {o[62:0], getb(d, 64, T_IP[i])};
    return o;
  endfunction

  // FP is the inverse of IP: bit i of the input lands on position IP[i].
  function automatic logic [63:0] m_fp(input logic [63:0] d);
    logic [63:0] o = '0;
    for (int i = 1; i <= 64; i++) if (getb(d, 64, i)) o = o | (64'd1 << (64 - T_IP[i-1]));
    return o;
  endfunction

  function automatic logic [47:0] m_e(input logic [31:0] r);
    logic [63:0] o = '0;
    for (int i = 0; i < 48; i++) o = {o[62:0], getb({32'd0, r}, 32, T_E[i])};
    return o[47:0];
  endfunction

  function automatic logic [31:0] m_p(input logic [31:0] s);
    logic [63:0] o = '0;
    for (int i = 0; i < 32; i++) o = {o[62:0], getb({32'd0, s}, 32, T_P[i])};
    return o[31:0];
  endfunction

  function automatic logic [31:0] m_sbox(input logic [47:0] x);
    logic [31:0] o = '0;
    int v, row, col;
    for (int s = 0; s < 8; s++) begin
      v   = int'((x >> (42 - 6*s)) & 48'h3f);
      row = ((v >> 5) & 1) * 2 + (v & 1);
      col = (v >> 1) & 15;
      o   = (o << 4) | 32'(T_S[s][row*16 + col]);
    end
    return o;
  endfunction

  task automatic gen_subkeys(input logic [63:0] key);
    logic [63:0] cd = '0;
    logic [63:0] k  = '0;
    logic [27:0] c, d;
    for (int i = 0; i < 56; i++) cd = {cd[62:0], getb(key, 64, T_PC1[i])};
    c = cd[55:28];
    d = cd[27:0];
    for (int rd = 1; rd <= 16; rd++) begin
      for (int s = 0; s < T_SH[rd-1]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      k = '0;
      for (int i = 0; i < 48; i++) k = {k[62:0], getb({8'd0, c, d}, 56, T_PC2[i])};
      sk[rd] = k[47:0];
    end
  endtask

  function automatic logic [63:0] des_ref(input logic [63:0] blk, input bit dec);
    logic [63:0] p;
    logic [31:0] l, r, t;
    p = m_ip(blk);
    l = p[63:32];
    r = p[31:0];
    for (int rd = 1; rd <= 16; rd++) begin
      t = r;
      r = l ^ m_p(m_sbox(m_e(r) ^ sk[dec ? 17 - rd : rd]));
      l = t;
    end
    return m_fp({r, l});
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  // Called #1 after a rising edge with the selected DUT idle.
  task automatic run_one(input int which, input logic [63:0] blk, output logic [63:0] res, output int lat);
    block_in = blk;
    if (which == 1) iv1 = 1'b1; else iv2 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0;
    iv2 = 1'b0;
    lat = 0;
    while (((which == 1) ? ov1 : ov2) !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    res = (which == 1) ? bo1 : bo2;
  endtask

  task automatic release_out(input int which);
    if (which == 1) ordy1 = 1'b1; else ordy2 = 1'b1;
    @(posedge clk); #1;
    ordy1 = 1'b0;
    ordy2 = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ir1 !== 1'b1) begin errors++; $display("FAIL reset_in_ready1: got %b want 1", ir1); end
    checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL reset_out_valid1: got %b want 0", ov1); end
    checks++; if (bo1 !== 64'd0) begin errors++; $display("FAIL reset_block_out1: got %h want 0", bo1); end
    checks++; if (ir2 !== 1'b1) begin errors++; $display("FAIL reset_in_ready2: got %b want 1", ir2); end
    checks++; if (ov2 !== 1'b0) begin errors++; $display("FAIL reset_out_valid2: got %b want 0", ov2); end
    checks++; if (bo2 !== 64'd0) begin errors++; $display("FAIL reset_block_out2: got %h want 0", bo2); end
    rst = 1'b0;
  endtask

  task automatic test_encrypt_vector;
    logic [63:0] res;
    int lat;
    gen_subkeys(64'h133457799BBCDFF1);
    run_one(1, 64'h0123456789ABCDEF, res, lat);
    checks++; if (lat != 16) begin errors++; $display("FAIL kat_latency: got %0d want 16", lat); end
    checks++; if (res !== 64'h85E813540F0AB405) begin errors++; $display("FAIL kat_encrypt: got %h want 85e813540f0ab405", res); end
    release_out(1);
    checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL kat_release_valid: got %b want 0", ov1); end
    checks++; if (ir1 !== 1'b1) begin errors++; $display("FAIL kat_release_ready: got %b want 1", ir1); end
  endtask

  task automatic test_random_encrypt;
    logic [63:0] blk, exp, res;
    int lat;
    for (int n = 0; n < 5; n++) begin
      gen_subkeys({$urandom, $urandom});
      blk = {$urandom, $urandom};
      exp = des_ref(blk, 1'b0);
      run_one(1, blk, res, lat);
      checks++; if (res !== exp) begin errors++; $display("FAIL rand_encrypt[%0d]: got %h want %h", n, res, exp); end
      checks++; if (lat != 16) begin errors++; $display("FAIL rand_latency[%0d]: got %0d want 16", n, lat); end
      release_out(1);
    end
  endtask

  task automatic test_backpressure;
    logic [63:0] blk, exp, res;
    int lat;
    blk = {$urandom, $urandom};
    exp = des_ref(blk, 1'b0);
    run_one(1, blk, res, lat);
    checks++; if (res !== exp) begin errors++; $display("FAIL bp_result: got %h want %h", res, exp); end
    // New traffic offered while DONE must be ignored.
    block_in = ~blk;
    iv1 = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++; if (bo1 !== exp) begin errors++; $display("FAIL bp_hold[%0d]: got %h want %h", c, bo1, exp); end
      checks++; if (ir1 !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", c, ir1); end
      checks++; if (ov1 !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d]: got %b want 1", c, ov1); end
    end
    iv1 = 1'b0;
    release_out(1);
    checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL bp_exit_valid: got %b want 0", ov1); end
    checks++; if (ir1 !== 1'b1) begin errors++; $display("FAIL bp_exit_ready: got %b want 1", ir1); end
  endtask

  task automatic test_reset_mid;
    logic [63:0] blk, exp, res;
    int lat;
    block_in = {$urandom, $urandom};
    iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", ov1); end
    checks++; if (ir1 !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", ir1); end
    checks++; if (bo1 !== 64'd0) begin errors++; $display("FAIL midrst_block_out: got %h want 0", bo1); end
    @(posedge clk); #1;
    rst = 1'b0;
    blk = {$urandom, $urandom};
    exp = des_ref(blk, 1'b0);
    run_one(1, blk, res, lat);
    checks++; if (res !== exp) begin errors++; $display("FAIL midrst_next: got %h want %h", res, exp); end
    checks++; if (lat != 16) begin errors++; $display("FAIL midrst_latency: got %0d want 16", lat); end
    #2 rst = 1'b1;
    #1;
    checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL donerst_valid: got %b want 0", ov1); end
    checks++; if (ir1 !== 1'b1) begin errors++; $display("FAIL donerst_ready: got %b want 1", ir1); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_unroll2;
    logic [63:0] blk, exp, res;
    int lat;
    gen_subkeys(64'h133457799BBCDFF1);
    run_one(2, 64'h0123456789ABCDEF, res, lat);
    checks++; if (lat != 8) begin errors++; $display("FAIL u2_kat_latency: got %0d want 8", lat); end
    checks++; if (res !== 64'h85E813540F0AB405) begin errors++; $display("FAIL u2_kat: got %h want 85e813540f0ab405", res); end
    release_out(2);
    for (int n = 0; n < 3; n++) begin
      gen_subkeys({$urandom, $urandom});
      blk = {$urandom, $urandom};
      exp = des_ref(blk, 1'b0);
      run_one(2, blk, res, lat);
      checks++; if (res !== exp) begin errors++; $display("FAIL u2_rand[%0d]: got %h want %h", n, res, exp); end
      checks++; if (lat != 8) begin errors++; $display("FAIL u2_latency[%0d]: got %0d want 8", n, lat); end
      release_out(2);
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] blks [3];
    logic [63:0] expq [$];
    logic [63:0] exp;
    int acc_cyc [$];
    int nout = 0;
    int nacc = 0;
    int cyc  = 0;
    logic will_acc;
    gen_subkeys({$urandom, $urandom});
    for (int i = 0; i < 3; i++) begin
      blks[i] = {$urandom, $urandom};
      expq.push_back(des_ref(blks[i], 1'b0));
    end
    ordy1    = 1'b1;
    iv1      = 1'b1;
    block_in = blks[0];
    while (nout < 3 && cyc < 100) begin
      will_acc = ir1 && iv1;
      @(posedge clk); #1;
      cyc++;
      if (will_acc) begin
        acc_cyc.push_back(cyc);
        nacc++;
        if (nacc < 3) block_in = blks[nacc];
        else iv1 = 1'b0;
      end
      if (ov1 === 1'b1) begin
        exp = expq.pop_front();
        checks++; if (bo1 !== exp) begin errors++; $display("FAIL b2b_result[%0d]: got %h want %h", nout, bo1, exp); end
        nout++;
      end
    end
    @(posedge clk); #1;
    ordy1 = 1'b0;
    iv1   = 1'b0;
    checks++; if (nout != 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", nout); end
    checks++; if (acc_cyc.size() != 3) begin errors++; $display("FAIL b2b_accepts: got %0d want 3", acc_cyc.size()); end
    else begin
      checks++; if (acc_cyc[1] - acc_cyc[0] != 18) begin errors++; $display("FAIL b2b_spacing01: got %0d want 18", acc_cyc[1] - acc_cyc[0]); end
      checks++; if (acc_cyc[2] - acc_cyc[1] != 18) begin errors++; $display("FAIL b2b_spacing12: got %0d want 18", acc_cyc[2] - acc_cyc[1]); end
    end
  endtask

`ifdef DES_DECRYPT_EN
  task automatic test_decrypt;
    logic [63:0] blk, exp, res;
    int lat;
    bit dec;
    gen_subkeys(64'h133457799BBCDFF1);
    mode = 1'b1;
    run_one(1, 64'h85E813540F0AB405, res, lat);
    checks++; if (res !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL kat_decrypt: got %h want 0123456789abcdef", res); end
    release_out(1);
    for (int n = 0; n < 4; n++) begin
      gen_subkeys({$urandom, $urandom});
      blk  = {$urandom, $urandom};
      dec  = 1'($urandom_range(1, 0));
      mode = dec;
      exp  = des_ref(blk, dec);
      run_one((n % 2) + 1, blk, res, lat);
      checks++; if (res !== exp) begin errors++; $display("FAIL rand_mode[%0d]: got %h want %h", n, res, exp); end
      release_out((n % 2) + 1);
    end
    mode = 1'b0;
  endtask
`endif

  initial begin
    rst      = 1'b1;
    iv1      = 1'b0;
    iv2      = 1'b0;
    ordy1    = 1'b0;
    ordy2    = 1'b0;
    block_in = '0;
`ifdef DES_DECRYPT_EN
    mode     = 1'b0;
`endif
    for (int i = 1; i <= 16; i++) sk[i] = '0;
    test_reset;
    test_encrypt_vector;
    test_random_encrypt;
    test_backpressure;
    test_reset_mid;
    test_unroll2;
    test_back_to_back;
`ifdef DES_DECRYPT_EN
    test_decrypt;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/des_round_engine.md
DES_ROUND_ENGINE -- requirements
Module: des_round_engine

Interface
REQ-001 SHALL have parameter UNROLL, default 1, giving the DES rounds computed per clock; legal values are 1 and 2.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: block_in is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the engine can accept a block.
REQ-006 SHALL have port block_in, input, 64 bits: input data block; DES bit n is vector index 64-n.
REQ-007 SHALL have ports subkey1 through subkey16, input, 48 bits each: round keys from the subkey generator; DES bit 1 is index 47.
REQ-008 SHALL have port mode, input, 1 bit, present only with DES_DECRYPT_EN: 0 encrypts, 1 decrypts; sampled at accept.
REQ-009 SHALL have port out_valid, output, 1 bit: block_out is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts block_out.
REQ-011 SHALL have port block_out, output, 64 bits: result block, same bit numbering as block_in.

Function
REQ-012 SHALL implement a three-state FSM:
- IDLE: in_ready=1.
- RUN: round iteration.
- DONE: out_valid=1.
REQ-013 SHALL accept a block when in_valid and in_ready are both high in IDLE, then:
- load L/R with IP(block_in);
- clear the round counter (5 bits);
- enter RUN.
REQ-014 In RUN, the engine SHALL apply UNROLL Feistel rounds per cycle: L'=R, R'=L xor f(R,K).
- f = E-expansion, then xor K, then S1..S8, then P.
REQ-015 SHALL add UNROLL to the round counter each RUN cycle, and go to DONE on the cycle in which round 16 completes.
REQ-016 SHALL select the round key as subkey(counter+1) for encrypt and subkey(16-counter) for decrypt.
REQ-017 SHALL register block_out as FP({R16,L16}), i.e. with the final swap, when entering DONE.
REQ-018 Accept-to-out_valid latency SHALL be exactly 16/UNROLL cycles: 16 for UNROLL=1, 8 for UNROLL=2.
REQ-019 SHALL hold out_valid and block_out stable in DONE until out_ready=1, then return to IDLE on that edge.
REQ-020 SHALL assert in_ready only in IDLE; there is no accept in the DONE-exit cycle, so blocks are separated by at least one bubble.
REQ-021 Subkey inputs SHALL be sampled every RUN cycle, not captured; upstream holds them stable from accept to output handshake, and the engine does not check this.
REQ-022 SHALL ignore in_valid while in RUN or DONE; out_ready outside DONE has no effect.
REQ-023 SHALL make every output a pure register or an FSM decode, with no combinational input-to-output paths.

Reset
REQ-024 On rst=1, the engine SHALL immediately enter IDLE and clear counter, L, R and block_out to 0.
- Outputs: out_valid=0, in_ready=1.
REQ-025 Reset asserted mid-RUN or in DONE SHALL discard the block in flight with no output produced.
REQ-026 After deassertion, the first accept SHALL be possible on the first rising edge with in_valid=1.

Configuration
REQ-027 Macro DES_DECRYPT_EN defined: the mode port exists and reverse key order is supported.
REQ-028 Macro DES_DECRYPT_EN undefined: the mode port and its register are absent, and the engine is encrypt-only (forward key order).

Structure
REQ-029 Package des_pkg SHALL hold the shared tables and types:
- IP, FP, E and P tables;
- S-box tables S1..S8 (8x64x4 bits);
- the FSM state enum;
- the 48-bit subkey and 64-bit block typedefs.
REQ-030 SHALL instantiate sub-module des_feistel_f (combinational: 32-bit R, 48-bit K, 32-bit f-output) UNROLL times.
- Instances are chained within one cycle when UNROLL=2.

Verification
REQ-031 Encrypt vector: key 133457799BBCDFF1 through the subkey generator, block 0123456789ABCDEF, UNROLL=1.
- Required: out_valid 16 cycles after accept, block_out = 85E813540F0AB405.
REQ-032 Decrypt vector (DES_DECRYPT_EN): same key, mode=1, block 85E813540F0AB405.
- Required: block_out = 0123456789ABCDEF.
REQ-033 Backpressure: hold out_ready=0 for 10 cycles after out_valid.
- Required: block_out held constant, in_ready=0 throughout.
- Required: IDLE reached on the edge where out_ready=1.
REQ-034 Reset mid-operation: assert rst at round 7.
- Required: out_valid=0 and in_ready=1 immediately.
- Required: the next block gives the correct result with no residue.
REQ-035 UNROLL=2 with the REQ-031 stimulus.
- Required: identical result with latency 8 cycles.
REQ-036 Back-to-back: in_valid held high with 3 blocks and out_ready=1.
- Required: three correct outputs, accept spacing 18 cycles (UNROLL=1).
